// File: rtl/shift_add_pkg.sv
// Shared constants and FSM state type for the sequential shift-add multiplier.
package shift_add_pkg;

  localparam int WIDTH = 4;
  localparam int CNT_W = 3;
  localparam logic [CNT_W-1:0] ITER_LAST = 3'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/shift_add_multiplier_if.sv
// Start/busy/done handshake bundle between a requester (master) and the multiplier (slave).
interface shift_add_multiplier_if;
  import shift_add_pkg::*;

  logic               start;
  logic [WIDTH-1:0]   multiplicand;
  logic [WIDTH-1:0]   multiplier;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  modport master (
    output start, multiplicand, multiplier,
    input  busy, done, product
  );

  modport slave (
    input  start, multiplicand, multiplier,
    output busy, done, product
  );

endinterface

// File: rtl/ripple_carry_4_bit_adder.sv
// 4-bit ripple-carry adder: {C_4,SUM} = A + B + C_0, built from a chain of full adders.
module ripple_carry_4_bit_adder (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       C_0,
  output logic [3:0] SUM,
  output logic       C_4
);

  logic [4:0] carry;

  assign carry[0] = C_0;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_fa
      assign SUM[gi]     = A[gi] ^ B[gi] ^ carry[gi];
      assign carry[gi+1] = (A[gi] & B[gi]) | (carry[gi] & (A[gi] ^ B[gi]));
    end
  endgenerate

  assign C_4 = carry[4];

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential 4x4 unsigned shift-add multiplier driving one ripple-carry adder per iteration.
// Optional build macro SHIFT_ADD_EARLY_EXIT_EN finishes as soon as the remaining multiplier bits are zero.
module shift_add_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  shift_add_multiplier_if.slave bus
);
  import shift_add_pkg::*;

  generate
    if (WIDTH != 4) begin : g_bad_width
      $error("shift_add_multiplier: WIDTH must be 4 to match the 4-bit adder");
    end
  endgenerate

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  logic [WIDTH-1:0]   addend;
  logic [WIDTH-1:0]   sum;
  logic               c4;
  logic [2*WIDTH-1:0] shifted;
  logic               last_iter;
  logic [2*WIDTH-1:0] final_product;

  assign addend = q_q[0] ? m_q : '0;

  ripple_carry_4_bit_adder u_adder (
    .A   (a_q),
    .B   (addend),
    .C_0 (1'b0),
    .SUM (sum),
    .C_4 (c4)
  );

  // {C_4,SUM,Q} >> 1: the carry becomes the top accumulator bit, SUM[0] enters Q.
  assign shifted = {c4, sum, q_q[WIDTH-1:1]};

`ifdef SHIFT_ADD_EARLY_EXIT_EN
  logic [WIDTH-1:0] rest_mask;
  logic             rest_zero;

  // Q[3-cnt:1] still hold unprocessed multiplier bits; once they are zero only shifts remain.
  assign rest_mask     = {WIDTH{1'b1}} >> (cnt_q + 3'd1);
  assign rest_zero     = ((q_q >> 1) & rest_mask) == '0;
  assign last_iter     = (cnt_q == ITER_LAST) || rest_zero;
  assign final_product = shifted >> (ITER_LAST - cnt_q);
`else
  assign last_iter     = (cnt_q == ITER_LAST);
  assign final_product = shifted;
`endif

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    q_d       = q_q;
    m_d       = m_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          m_d     = bus.multiplicand;
          q_d     = bus.multiplier;
          a_d     = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d   = shifted[2*WIDTH-1:WIDTH];
        q_d   = shifted[WIDTH-1:0];
        cnt_d = cnt_q + 3'd1;
        if (last_iter) begin
          product_d = final_product;
          state_d   = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      q_q       <= '0;
      m_q       <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      q_q       <= q_d;
      m_q       <= m_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign bus.busy    = (state_q == RUN);
  assign bus.done    = (state_q == DONE);
  assign bus.product = product_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Self-checking bench for shift_add_multiplier: scoreboard of expected products, latency and handshake checks.
module tb_shift_add_multiplier;
  import shift_add_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  shift_add_multiplier_if bus ();

  shift_add_multiplier #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] sb[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected start->done latency in cycles for a given multiplier value.
  function automatic int exp_latency(input logic [3:0] q);
`ifdef SHIFT_ADD_EARLY_EXIT_EN
    int h;
    h = 0;
    for (int i = 0; i < 4; i++) if (q[i]) h = i;
    return 2 + h;
`else
    return 5;
`endif
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.multiplicand = 4'd0;
    bus.multiplier = 4'd0;
    tick();
    tick();
    checks++;
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++;
    if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", bus.done); end
    checks++;
    if (bus.product !== 8'h00) begin failures++; $display("FAIL reset_product: got %h want 00", bus.product); end
    rst = 1'b0;
    tick();
    checks++;
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL idle_busy: got %b want 0", bus.busy); end
    $display("reset: busy=%b done=%b product=%h", bus.busy, bus.done, bus.product);
  endtask

  task automatic test_op(input logic [3:0] m, input logic [3:0] q);
    int         lat;
    int         busy_cnt;
    logic [7:0] exp_p;
    bus.multiplicand = m;
    bus.multiplier   = q;
    bus.start        = 1'b1;
    sb.push_back({4'b0, m} * {4'b0, q});
    tick();
    bus.start        = 1'b0;
    // Scramble the operand inputs while running; the captured values must be used.
    bus.multiplicand = ~m;
    bus.multiplier   = ~q;
    lat      = 1;
    busy_cnt = 0;
    while (!bus.done && lat < 12) begin
      if (bus.busy) busy_cnt++;
      tick();
      lat++;
    end
    checks++;
    if (!bus.done) begin
      failures++;
      $display("FAIL op_timeout: %0d*%0d no done within %0d cycles", m, q, lat);
      void'(sb.pop_front());
      return;
    end
    exp_p = sb.pop_front();
    checks++;
    if (lat !== exp_latency(q)) begin failures++; $display("FAIL op_latency: %0d*%0d got %0d want %0d", m, q, lat, exp_latency(q)); end
    checks++;
    if (busy_cnt !== exp_latency(q) - 1) begin failures++; $display("FAIL op_busy_cycles: %0d*%0d got %0d want %0d", m, q, busy_cnt, exp_latency(q) - 1); end
    checks++;
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL op_busy_at_done: got %b want 0", bus.busy); end
    checks++;
    if (bus.product !== exp_p) begin failures++; $display("FAIL op_product: %0d*%0d got %0d want %0d", m, q, bus.product, exp_p); end
    tick();
    checks++;
    if (bus.done !== 1'b0) begin failures++; $display("FAIL op_done_pulse: got %b want 0", bus.done); end
    checks++;
    if (bus.product !== exp_p) begin failures++; $display("FAIL op_product_hold: got %0d want %0d", bus.product, exp_p); end
    $display("op: %0d*%0d product=%0d latency=%0d busy_cycles=%0d", m, q, bus.product, lat, busy_cnt);
  endtask

  task automatic test_back_to_back();
    int         last_done;
    int         n_done;
    int         spacing;
    logic [7:0] exp_p;
    last_done = -1;
    n_done    = 0;
    spacing   = exp_latency(4'd1) + 1;
    bus.start = 1'b1;
    for (int i = 0; i < 20 + 12; i++) begin
      if (i == 20) bus.start = 1'b0;
      if (!bus.busy && !bus.done) begin
        bus.multiplicand = 4'd7;
        bus.multiplier   = 4'd1;
        if (bus.start) sb.push_back(8'd7);
      end else begin
        bus.multiplicand = 4'($urandom_range(0, 15));
        bus.multiplier   = 4'($urandom_range(0, 15));
      end
      tick();
      if (bus.done) begin
        n_done++;
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL b2b_unexpected_done: cycle %0d product=%0d", i + 1, bus.product);
        end else begin
          exp_p = sb.pop_front();
          if (bus.product !== exp_p) begin failures++; $display("FAIL b2b_product: got %0d want %0d", bus.product, exp_p); end
        end
        if (last_done >= 0) begin
          checks++;
          if (i + 1 - last_done !== spacing) begin failures++; $display("FAIL b2b_spacing: got %0d want %0d", i + 1 - last_done, spacing); end
        end
        $display("b2b: done at cycle %0d product=%0d", i + 1, bus.product);
        last_done = i + 1;
      end
      if (i >= 20 && sb.size() == 0 && !bus.busy) break;
    end
    checks++;
    if (sb.size() !== 0) begin failures++; $display("FAIL b2b_drain: %0d results outstanding", sb.size()); end
    checks++;
    if (n_done < 3) begin failures++; $display("FAIL b2b_count: got %0d done pulses want >=3", n_done); end
    sb.delete();
    tick();
    tick();
  endtask

  task automatic test_reset_mid_run();
    bus.multiplicand = 4'd9;
    bus.multiplier   = 4'd9;
    bus.start        = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    checks++;
    if (bus.busy !== 1'b1) begin failures++; $display("FAIL midrst_busy_before: got %b want 1", bus.busy); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %b want 0", bus.busy); end
    checks++;
    if (bus.done !== 1'b0) begin failures++; $display("FAIL midrst_done: got %b want 0", bus.done); end
    checks++;
    if (bus.product !== 8'h00) begin failures++; $display("FAIL midrst_product: got %h want 00", bus.product); end
    $display("midrst: busy=%b done=%b product=%h", bus.busy, bus.done, bus.product);
    test_op(4'd2, 4'd3);
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      test_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end
  endtask

  initial begin
    test_reset();
    test_op(4'd13, 4'd11);
    test_op(4'd15, 4'd15);
    test_back_to_back();
    test_reset_mid_run();
    test_op(4'd12, 4'd0);
    test_op(4'd3, 4'd1);
    test_op(4'd1, 4'd8);
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
